// File: rtl/pipe_pkg.sv
// Shared types and defaults for the EX->WB pipeline lane registers.
// The lane payload is sized to the widest supported pc/data/ecode so the
// same struct serves every parameterisation; narrower instances zero-extend.
package pipe_pkg;

    localparam int LANES_DEF   = 2;
    localparam int STAGES_DEF  = 2;
    localparam int ECODE_W     = 7;
    localparam int DATA_MAX_W  = 64;
    localparam int ECODE_MAX_W = 16;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [4:0]             waddr;
        logic [DATA_MAX_W-1:0]  pc;
        logic [DATA_MAX_W-1:0]  data;
        logic [ECODE_MAX_W-1:0] ecode;
    } lane_t;

endpackage

// File: rtl/pipe_lane_regs_if.sv
// Bus bundle for pipe_lane_regs: stage-0 lane inputs, per-bank recomputed
// data, stall/flush controls and the flattened bank outputs.
// Handshake: there is no valid/ready pair; hold[s] is a stall request that
// freezes bank s and every earlier bank, flush kills all banks at the edge.
interface pipe_lane_regs_if #(
    parameter int LANES   = pipe_pkg::LANES_DEF,
    parameter int STAGES  = pipe_pkg::STAGES_DEF,
    parameter int DATA_W  = 32,
    parameter int ECODE_W = pipe_pkg::ECODE_W
);
    // stage_data is kept at least one bit wide for a single-bank build
    localparam int SD_W  = (STAGES > 1) ? (STAGES - 1) * LANES * DATA_W : 1;
    localparam int CNT_W = $clog2(LANES + 1);

    logic [LANES-1:0]                 in_valid;
    logic [LANES-1:0]                 in_we;
    logic [LANES-1:0]                 br_kill;
    logic [LANES*DATA_W-1:0]          in_pc;
    logic [LANES*DATA_W-1:0]          in_data;
    logic [LANES*5-1:0]               in_waddr;
    logic [LANES*ECODE_W-1:0]         in_ecode;
    logic [SD_W-1:0]                  stage_data;
    logic [STAGES-1:0]                hold;
    logic                             flush;

    logic [STAGES*LANES-1:0]          out_valid;
    logic [STAGES*LANES-1:0]          out_we;
    logic [STAGES*LANES*DATA_W-1:0]   out_pc;
    logic [STAGES*LANES*DATA_W-1:0]   out_data;
    logic [STAGES*LANES*5-1:0]        out_waddr;
    logic [STAGES*LANES*ECODE_W-1:0]  out_ecode;
    logic [CNT_W-1:0]                 retire_cnt;

    modport slave (
        input  in_valid, in_we, br_kill, in_pc, in_data, in_waddr, in_ecode,
               stage_data, hold, flush,
        output out_valid, out_we, out_pc, out_data, out_waddr, out_ecode,
               retire_cnt
    );

    modport master (
        output in_valid, in_we, br_kill, in_pc, in_data, in_waddr, in_ecode,
               stage_data, hold, flush,
        input  out_valid, out_we, out_pc, out_data, out_waddr, out_ecode,
               retire_cnt
    );

endinterface

// File: rtl/pipe_bank.sv
// One register bank of LANES lanes: hold, bubble insertion, younger-lane
// kill behind a redirect, write squash behind an exception, and flush.
module pipe_bank import pipe_pkg::*; #(
    parameter int LANES = LANES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  bubble,
    input  logic [LANES-1:0]      kill,
    input  lane_t [LANES-1:0]     src,
    output lane_t [LANES-1:0]     q
);

    logic [LANES-1:0]  killed;
    logic [LANES-1:0]  excp;
    lane_t [LANES-1:0] nxt;

    // A lane is killed by any older redirect, squashed by any older-or-same faulting lane
    always_comb begin
        killed = '0;
        excp   = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < i; j++) begin
                killed[i] = killed[i] | kill[j];
            end
            for (int j = 0; j <= i; j++) begin
                excp[i] = excp[i] | (src[j].valid & (src[j].ecode != '0));
            end
        end
    end

    // Load value per lane; an invalid lane never carries a write enable
    always_comb begin
        nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            nxt[i] = src[i];
            if (excp[i]) begin
                nxt[i].we = 1'b0;
            end
            if (killed[i]) begin
                nxt[i] = '0;
            end
            if (!nxt[i].valid) begin
                nxt[i].we = 1'b0;
            end
        end
    end

    // Bank register: reset, then flush, then hold, then bubble or load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            for (int i = 0; i < LANES; i++) begin
                q[i].valid <= 1'b0;
                q[i].we    <= 1'b0;
            end
        end else if (!hold) begin
            q <= bubble ? '0 : nxt;
        end
    end

endmodule

// File: rtl/pipe_lane_regs.sv
// Multi-lane EX->WB pipeline register chain. Bank 0 captures the issue
// lanes, each later bank takes the previous bank with a recomputed result.
module pipe_lane_regs #(
    parameter int LANES   = pipe_pkg::LANES_DEF,
    parameter int STAGES  = pipe_pkg::STAGES_DEF,
    parameter int DATA_W  = 32,
    parameter int ECODE_W = pipe_pkg::ECODE_W
) (
    input  logic              clk,
    input  logic              rst,
    pipe_lane_regs_if.slave   bus
);
    import pipe_pkg::*;

    localparam int CNT_W = $clog2(LANES + 1);

    logic [STAGES-1:0] he;
    logic [STAGES-1:0] bubble;
    logic [LANES-1:0]  bank_kill [STAGES];
    lane_t [LANES-1:0] bank_src  [STAGES];
    lane_t [LANES-1:0] bank_q    [STAGES];
    logic              unused_bits;

    // A stall in any later bank back-pressures every earlier bank
    always_comb begin
        he     = '0;
        bubble = '0;
        for (int s = 0; s < STAGES; s++) begin
            he[s] = |(bus.hold >> s);
        end
        for (int s = 1; s < STAGES; s++) begin
            bubble[s] = he[s-1];
        end
    end

    // Assemble each bank's load source: issue ports for bank 0, previous bank otherwise
    always_comb begin
        bank_src  = '{default: '0};
        bank_kill = '{default: '0};
        bank_kill[0] = bus.br_kill;
        for (int i = 0; i < LANES; i++) begin
            bank_src[0][i].valid = bus.in_valid[i];
            bank_src[0][i].we    = bus.in_we[i];
            bank_src[0][i].waddr = bus.in_waddr[i*5 +: 5];
            bank_src[0][i].pc    = DATA_MAX_W'(bus.in_pc[i*DATA_W +: DATA_W]);
            bank_src[0][i].data  = DATA_MAX_W'(bus.in_data[i*DATA_W +: DATA_W]);
            bank_src[0][i].ecode = ECODE_MAX_W'(bus.in_ecode[i*ECODE_W +: ECODE_W]);
        end
        for (int s = 1; s < STAGES; s++) begin
            for (int i = 0; i < LANES; i++) begin
                bank_src[s][i]      = bank_q[s-1][i];
                bank_src[s][i].data = DATA_MAX_W'(bus.stage_data[((s-1)*LANES+i)*DATA_W +: DATA_W]);
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_bank
        pipe_bank #(.LANES(LANES)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .flush  (bus.flush),
            .hold   (he[s]),
            .bubble (bubble[s]),
            .kill   (bank_kill[s]),
            .src    (bank_src[s]),
            .q      (bank_q[s])
        );
    end

    // Outputs are straight register taps, narrowed to the configured widths
    always_comb begin
        bus.out_valid = '0;
        bus.out_we    = '0;
        bus.out_pc    = '0;
        bus.out_data  = '0;
        bus.out_waddr = '0;
        bus.out_ecode = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < LANES; i++) begin
                bus.out_valid[s*LANES+i]                     = bank_q[s][i].valid;
                bus.out_we[s*LANES+i]                        = bank_q[s][i].we;
                bus.out_pc[(s*LANES+i)*DATA_W +: DATA_W]     = bank_q[s][i].pc[DATA_W-1:0];
                bus.out_data[(s*LANES+i)*DATA_W +: DATA_W]   = bank_q[s][i].data[DATA_W-1:0];
                bus.out_waddr[(s*LANES+i)*5 +: 5]            = bank_q[s][i].waddr;
                bus.out_ecode[(s*LANES+i)*ECODE_W +: ECODE_W] = bank_q[s][i].ecode[ECODE_W-1:0];
            end
        end
    end

    // Retiring writes: valid lanes with we set in the last bank
    always_comb begin
        bus.retire_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.retire_cnt = bus.retire_cnt
                           + CNT_W'(bank_q[STAGES-1][i].valid & bank_q[STAGES-1][i].we);
        end
    end

    // Zero-extended upper bits of the wide payload are never observed
    always_comb begin
        unused_bits = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < LANES; i++) begin
                unused_bits = unused_bits
                            ^ (^{bank_q[s][i].pc, bank_q[s][i].data, bank_q[s][i].ecode});
            end
        end
    end

endmodule
